or16_response_checker: RTL

- Sequential self-checking monitor on the observing side of the 16-bit OR gate's stimulus interface.
- A stimulus driver presents operand pairs. This block accepts each pair together with the gate's output over a valid/ready handshake.
- For each sample it computes the expected bitwise OR, compares it with the observed result, and counts passes and fails.
- It records the first failure, detects a stalled driver with a timeout, and reports a final done/error status. Benches and a future hardware self-test use it in place of manual waveform inspection.

---
 rtl/or16_response_checker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/or16_response_checker.sv
// Response checker for a 16-bit OR gate: accepts {in0, in1, dut_out} samples over a
// valid/ready handshake, counts pass/fail, captures the first mismatch and flags stalls.
module or16_response_checker #(
    parameter int unsigned width          = 16,
    parameter int unsigned num_samples    = 3,
    parameter int unsigned timeout_cycles = 64,
    parameter int unsigned cnt_w          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             timeout,
    output logic [cnt_w-1:0] pass_count,
    output logic [cnt_w-1:0] fail_count,
    output logic [cnt_w-1:0] first_fail_index,
    output logic [width-1:0] first_fail_expected,
    output logic [width-1:0] first_fail_actual
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [cnt_w-1:0] pass_q;
    logic [cnt_w-1:0] fail_q;
    logic [cnt_w-1:0] acc_q;
    logic [cnt_w-1:0] idle_q;
    logic [cnt_w-1:0] ffi_q;
    logic [width-1:0] ffe_q;
    logic [width-1:0] ffa_q;
    logic             err_q;
    logic             to_q;

    logic             accept;
    logic             mismatch;
    logic [width-1:0] expected;
    logic [cnt_w-1:0] acc_d;
    logic [cnt_w-1:0] idle_d;

    always_comb begin
        accept   = (state_q == S_RUN) && sample_valid;
        expected = in0 | in1;
        // Case inequality: any X/Z on the observed result is a mismatch.
        mismatch = (dut_out !== expected);
        acc_d    = acc_q + cnt_w'(1);
        idle_d   = idle_q + cnt_w'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            fail_q  <= '0;
            acc_q   <= '0;
            idle_q  <= '0;
            ffi_q   <= '0;
            ffe_q   <= '0;
            ffa_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pass_q  <= '0;
                        fail_q  <= '0;
                        acc_q   <= '0;
                        idle_q  <= '0;
                        ffi_q   <= '0;
                        ffe_q   <= '0;
                        ffa_q   <= '0;
                        err_q   <= 1'b0;
                        to_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        acc_q  <= acc_d;
                        idle_q <= '0;
                        if (mismatch) begin
                            fail_q <= fail_q + cnt_w'(1);
                            err_q  <= 1'b1;
                            if (fail_q == '0) begin
                                ffi_q <= acc_q;
                                ffe_q <= expected;
                                ffa_q <= dut_out;
                            end
                        end else begin
                            pass_q <= pass_q + cnt_w'(1);
                        end
                        if (acc_d == cnt_w'(num_samples)) state_q <= S_DONE;
                    end else begin
                        // An accept in the would-be timeout cycle takes precedence.
                        idle_q <= idle_d;
                        if (idle_d == cnt_w'(timeout_cycles)) begin
                            state_q <= S_DONE;
                            to_q    <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample_ready        = (state_q == S_RUN);
    assign busy                = (state_q == S_RUN);
    assign done                = (state_q == S_DONE);
    assign error               = err_q;
    assign timeout             = to_q;
    assign pass_count          = pass_q;
    assign fail_count          = fail_q;
    assign first_fail_index    = ffi_q;
    assign first_fail_expected = ffe_q;
    assign first_fail_actual   = ffa_q;

endmodule
